line_buffer_input_fifo: RTL and testbench
=========================================

Name: line_buffer_input_fifo

Overview:
- Synchronous pixel FIFO placed directly upstream of the line buffer.
- Accepts one full pixel per beat (all IN_CHANNEL channels packed) from the feature-map source over a valid/ready interface.
- Serves the line buffer through its fifo_rd_en / i_valid / fifo_almost_full interface.
- Decouples bursty source traffic from the line buffer's padding-driven, stall-prone read pattern.

Parameters:
- DATA_WIDTH, 16, bits per channel sample
- IN_CHANNEL, 16, channels per pixel; PIXEL_WIDTH = DATA_WIDTH*IN_CHANNEL
- DEPTH, 64, storage entries; power of two, >= 4
- ALMOST_FULL_THRESH, 56, occupancy at or above which fifo_almost_full asserts; 1 <= value <= DEPTH

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- s_data  in  PIXEL_WIDTH  pixel from upstream source
- s_valid  in  1  s_data valid
- s_ready  out  1  FIFO can accept; beat transfers when s_valid && s_ready
- fifo_rd_en  in  1  read request from the line buffer
- o_data  out  PIXEL_WIDTH  read pixel; drives line buffer i_data
- o_valid  out  1  o_data valid; drives line buffer i_valid
- fifo_almost_full  out  1  occupancy >= ALMOST_FULL_THRESH
- fifo_empty  out  1  occupancy == 0
- fifo_count  out  $clog2(DEPTH+1)  current occupancy
- overflow_err  out  1  sticky: a write beat was presented while full
- underflow_err  out  1  sticky: fifo_rd_en asserted while empty

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr = rd_ptr = 0, fifo_count = 0
  - o_valid = 0, o_data = 0
  - fifo_empty = 1, fifo_almost_full = 0, s_ready = 1
  - overflow_err = underflow_err = 0
  - Storage contents are don't-care.
  - Reset mid-operation discards all contents; no partial beat is emitted afterwards.
- Flags:
  - s_ready, fifo_empty and fifo_almost_full are decoded from the registered fifo_count only; there is no combinational path from fifo_rd_en or s_valid.
  - s_ready = (fifo_count < DEPTH).
- Write:
  - When s_valid && s_ready, store s_data at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap, log2(DEPTH) bits).
- Read (1-cycle latency, no fall-through):
  - When fifo_rd_en && !fifo_empty, o_data <= mem[rd_ptr] and o_valid <= 1 on the next edge; rd_ptr increments modulo DEPTH.
  - Otherwise o_valid <= 0 and o_data holds its last value.
- Occupancy per edge:
  - Write only: +1.
  - Read only: -1.
  - Both or neither: unchanged.
- Simultaneous events:
  - Empty plus write plus rd_en: the write is accepted, the read is ignored (o_valid = 0 next cycle), and underflow_err is set.
  - Full plus read plus s_valid: the read is performed, the write is refused (s_ready = 0 this cycle), and overflow_err is set. The count becomes DEPTH-1, so s_ready = 1 the next cycle.
  - Any other simultaneous read and write proceed together; the count is unchanged.
- Error flags:
  - overflow_err sets when s_valid && !s_ready.
  - underflow_err sets when fifo_rd_en && fifo_empty.
  - Both clear only on rst.
  - Refused or ignored operations never change pointers, count or storage.
- Ordering: strict FIFO; no beat is dropped or duplicated while the protocol is obeyed.
- Storage: inferable as simple dual-port RAM (one write port, one registered read port).

Test Plan:
- Reset then idle:
  - Required: fifo_empty = 1, s_ready = 1, fifo_count = 0, o_valid = 0, both error flags 0.
  - Apply rst for 1 ns mid-cycle: outputs return to these values immediately.
- Fill, default params:
  - Write 64 beats with data = index 0..63, no reads.
  - Required: fifo_almost_full rises the cycle after the 56th write (count = 56); s_ready = 0 after the 64th.
  - A 65th s_valid sets overflow_err, and count stays 64.
- Drain order:
  - From full, hold fifo_rd_en for 64 cycles.
  - Required: o_valid is high for 64 consecutive cycles starting one cycle after the first rd_en, carrying o_data 0..63 in order; then fifo_empty = 1.
  - A further rd_en sets underflow_err and leaves o_valid = 0.
- Wrap-around streaming:
  - Continuous writes and reads, 200 beats, count held at 3.
  - Required: output sequence equals input sequence, pointers wrap past 63, and fifo_count stays 3.
- Boundary simultaneity:
  - At count 0, assert s_valid and rd_en together: count becomes 1, o_valid = 0, underflow_err = 1.
  - At count 64, assert s_valid and rd_en together: count becomes 63, one valid read, overflow_err = 1.
- Line-buffer backpressure pattern:
  - Random s_valid (70%) and random rd_en (40%) for 5000 cycles against a scoreboard.
  - Required: no data mismatch, no error flags, and fifo_count always equals writes minus reads.

Source files
------------

// File: rtl/line_buffer_input_fifo.sv
// Pixel FIFO sitting directly upstream of the line buffer.
// Valid/ready write side from the feature-map source; the read side is a
// rd_en / o_valid pair with one cycle of latency and no fall-through.
// Flags are decoded only from the registered occupancy, so neither s_valid
// nor fifo_rd_en has a combinational path to any output.
module line_buffer_input_fifo #(
  parameter int DATA_WIDTH         = 16,
  parameter int IN_CHANNEL         = 16,
  parameter int DEPTH              = 64,
  parameter int ALMOST_FULL_THRESH = 56,
  localparam int PIXEL_WIDTH       = DATA_WIDTH * IN_CHANNEL,
  localparam int CW                = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIXEL_WIDTH-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   fifo_rd_en,
  output logic [PIXEL_WIDTH-1:0] o_data,
  output logic                   o_valid,
  output logic                   fifo_almost_full,
  output logic                   fifo_empty,
  output logic [CW-1:0]          fifo_count,
  output logic                   overflow_err,
  output logic                   underflow_err
);

  localparam int AW = $clog2(DEPTH);

  // Storage carries no reset so it maps onto a simple dual-port RAM.
  logic [PIXEL_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          wr_en;
  logic          rd_en;

  // Flags come straight off the registered occupancy.
  assign s_ready          = (count_reg < CW'(DEPTH));
  assign fifo_empty       = (count_reg == '0);
  assign fifo_almost_full = (count_reg >= CW'(ALMOST_FULL_THRESH));
  assign fifo_count       = count_reg;

  // Qualified operations: refused writes and ignored reads do nothing.
  assign wr_en = s_valid && s_ready;
  assign rd_en = fifo_rd_en && !fifo_empty;

  // Occupancy moves by one on a lone write or read; a paired op cancels out.
  always_comb begin
    count_next = count_reg;
    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // RAM write port. A write never lands on the address being read in the
  // same cycle: equal pointers mean empty (read blocked) or full (write blocked).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= s_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Registered read port; o_data holds its last value when no read occurs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= rd_en;
      if (rd_en) o_data <= mem[rd_ptr_reg];
    end
  end

  // Sticky protocol-violation flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (s_valid && !s_ready)       overflow_err  <= 1'b1;
      if (fifo_rd_en && fifo_empty)  underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_line_buffer_input_fifo.sv
// Directed testbench for line_buffer_input_fifo at default parameters.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, i.e. they reflect the edge that has just occurred.
module tb_line_buffer_input_fifo;

  localparam int DW    = 16;
  localparam int NCH   = 16;
  localparam int DEPTH = 64;
  localparam int AFT   = 56;
  localparam int PW    = DW * NCH;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          fifo_rd_en;
  logic [PW-1:0] o_data;
  logic          o_valid;
  logic          fifo_almost_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          overflow_err;
  logic          underflow_err;

  int n_cmp  = 0;
  int n_fail = 0;

  line_buffer_input_fifo #(
    .DATA_WIDTH(DW), .IN_CHANNEL(NCH), .DEPTH(DEPTH), .ALMOST_FULL_THRESH(AFT)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .fifo_rd_en(fifo_rd_en), .o_data(o_data), .o_valid(o_valid),
    .fifo_almost_full(fifo_almost_full), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] rand_pixel();
    logic [PW-1:0] v = '0;
    for (int k = 0; k < (PW + 31) / 32; k++) v = (v << 32) | PW'($urandom);
    return v;
  endfunction

  task automatic pulse_reset();
    rst = 1'b1; s_valid = 1'b0; fifo_rd_en = 1'b0; s_data = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; fifo_rd_en = 1'b0; s_data = '0;
    step(); step();
    rst = 1'b0;
    step();
    n_cmp++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b want=1", fifo_empty); end
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got=%b want=1", s_ready); end
    n_cmp++; if (fifo_count !== CW'(0)) begin n_fail++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid got=%b want=0", o_valid); end
    n_cmp++; if (fifo_almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full got=%b want=0", fifo_almost_full); end
    n_cmp++; if ({overflow_err, underflow_err} !== 2'b00) begin n_fail++; $display("FAIL reset_errs got=%b%b want=00", overflow_err, underflow_err); end
    $display("test_reset done");
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1; s_data = PW'(i);
      step();
      n_cmp++; if (fifo_count !== CW'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, fifo_count, i + 1); end
      n_cmp++; if (fifo_almost_full !== (i + 1 >= AFT)) begin n_fail++; $display("FAIL fill_almost_full[%0d] got=%b want=%b", i, fifo_almost_full, (i + 1 >= AFT)); end
      n_cmp++; if (s_ready !== (i + 1 < DEPTH)) begin n_fail++; $display("FAIL fill_s_ready[%0d] got=%b want=%b", i, s_ready, (i + 1 < DEPTH)); end
    end
    s_data = PW'(999);
    step();
    s_valid = 1'b0;
    n_cmp++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL fill_overflow got=%b want=1", overflow_err); end
    n_cmp++; if (fifo_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fill_overflow_count got=%0d want=%0d", fifo_count, DEPTH); end
    $display("test_fill done");
  endtask

  task automatic test_drain();
    fifo_rd_en = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      step();
      n_cmp++; if (o_valid !== 1'b1 || o_data !== PW'(j)) begin
        n_fail++; $display("FAIL drain_data[%0d] got valid=%b data=%0h want valid=1 data=%0h", j, o_valid, o_data, j);
      end
    end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%b want=1", fifo_empty); end
    n_cmp++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL drain_early_underflow got=%b want=0", underflow_err); end
    step();
    fifo_rd_en = 1'b0;
    n_cmp++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL drain_underflow got=%b want=1", underflow_err); end
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL drain_extra_valid got=%b want=0", o_valid); end
    n_cmp++; if (o_data !== PW'(DEPTH - 1)) begin n_fail++; $display("FAIL drain_hold got=%0h want=%0h", o_data, DEPTH - 1); end
    $display("test_drain done");
  endtask

  task automatic test_mid_reset();
    s_valid = 1'b1; s_data = PW'(16'hABCD);
    step();
    s_valid = 1'b1; s_data = PW'(16'h1234); fifo_rd_en = 1'b1;
    step();
    s_valid = 1'b0; fifo_rd_en = 1'b0;
    n_cmp++; if (o_valid !== 1'b1 || o_data !== PW'(16'hABCD)) begin
      n_fail++; $display("FAIL mid_pre_read got valid=%b data=%0h want valid=1 data=abcd", o_valid, o_data);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (o_valid !== 1'b0 || o_data !== '0) begin n_fail++; $display("FAIL mid_reset_out got valid=%b data=%0h want 0/0", o_valid, o_data); end
    n_cmp++; if (fifo_count !== CW'(0) || fifo_empty !== 1'b1 || s_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_flags got count=%0d empty=%b ready=%b want 0/1/1", fifo_count, fifo_empty, s_ready);
    end
    n_cmp++; if ({overflow_err, underflow_err} !== 2'b00) begin n_fail++; $display("FAIL mid_reset_errs got=%b%b want=00", overflow_err, underflow_err); end
    rst = 1'b0;
    step();
    n_cmp++; if (o_valid !== 1'b0 || fifo_count !== CW'(0)) begin n_fail++; $display("FAIL mid_reset_after got valid=%b count=%0d want 0/0", o_valid, fifo_count); end
    $display("test_mid_reset done");
  endtask

  task automatic test_boundary();
    s_valid = 1'b1; s_data = PW'(16'h0100); fifo_rd_en = 1'b1;
    step();
    fifo_rd_en = 1'b0;
    n_cmp++; if (fifo_count !== CW'(1)) begin n_fail++; $display("FAIL bnd_empty_count got=%0d want=1", fifo_count); end
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bnd_empty_valid got=%b want=0", o_valid); end
    n_cmp++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL bnd_empty_underflow got=%b want=1", underflow_err); end
    for (int i = 1; i < DEPTH; i++) begin
      s_data = PW'(16'h0100 + i);
      step();
    end
    n_cmp++; if (fifo_count !== CW'(DEPTH) || overflow_err !== 1'b0) begin
      n_fail++; $display("FAIL bnd_full_pre got count=%0d ovf=%b want %0d/0", fifo_count, overflow_err, DEPTH);
    end
    s_data = PW'(16'h0999); fifo_rd_en = 1'b1;
    step();
    s_valid = 1'b0; fifo_rd_en = 1'b0;
    n_cmp++; if (fifo_count !== CW'(DEPTH - 1)) begin n_fail++; $display("FAIL bnd_full_count got=%0d want=%0d", fifo_count, DEPTH - 1); end
    n_cmp++; if (o_valid !== 1'b1 || o_data !== PW'(16'h0100)) begin
      n_fail++; $display("FAIL bnd_full_read got valid=%b data=%0h want valid=1 data=100", o_valid, o_data);
    end
    n_cmp++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL bnd_full_overflow got=%b want=1", overflow_err); end
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bnd_full_ready got=%b want=1", s_ready); end
    // The refused 0x999 must not be in the queue: drain and check the tail.
    fifo_rd_en = 1'b1;
    for (int i = 1; i < DEPTH; i++) step();
    fifo_rd_en = 1'b0;
    n_cmp++; if (o_data !== PW'(16'h0100 + DEPTH - 1) || fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL bnd_tail got data=%0h empty=%b want data=%0h empty=1", o_data, fifo_empty, 16'h0100 + DEPTH - 1);
    end
    $display("test_boundary done");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = PW'(1000 + i);
      step();
    end
    for (int i = 0; i < 200; i++) begin
      s_valid = 1'b1; s_data = PW'(1003 + i); fifo_rd_en = 1'b1;
      step();
      n_cmp++; if (fifo_count !== CW'(3)) begin n_fail++; $display("FAIL stream_count[%0d] got=%0d want=3", i, fifo_count); end
      n_cmp++; if (o_valid !== 1'b1 || o_data !== PW'(1000 + i)) begin
        n_fail++; $display("FAIL stream_data[%0d] got valid=%b data=%0d want valid=1 data=%0d", i, o_valid, o_data, 1000 + i);
      end
    end
    s_valid = 1'b0; fifo_rd_en = 1'b0;
    n_cmp++; if ({overflow_err, underflow_err} !== 2'b00) begin n_fail++; $display("FAIL stream_errs got=%b%b want=00", overflow_err, underflow_err); end
    $display("test_back_to_back done");
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] q[$];
    logic [PW-1:0] exp;
    logic          did_rd;
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    int            bad = 0;
    for (int c = 0; c < 5000; c++) begin
      s_valid    = ($urandom_range(99) < 70) && s_ready;
      fifo_rd_en = ($urandom_range(99) < 40) && !fifo_empty;
      s_data     = rand_pixel();
      did_rd     = fifo_rd_en;
      exp        = '0;
      if (did_rd) begin exp = q.pop_front(); rd_cnt++; end
      if (s_valid) begin q.push_back(s_data); wr_cnt++; end
      step();
      if (did_rd) begin
        n_cmp++; if (o_valid !== 1'b1 || o_data !== exp) begin
          n_fail++; bad++;
          if (bad < 10) $display("FAIL bp_data[%0d] got valid=%b data=%0h want valid=1 data=%0h", c, o_valid, o_data, exp);
        end
      end else begin
        n_cmp++; if (o_valid !== 1'b0) begin
          n_fail++; bad++;
          if (bad < 10) $display("FAIL bp_valid[%0d] got=%b want=0", c, o_valid);
        end
      end
      n_cmp++; if (fifo_count !== CW'(wr_cnt - rd_cnt)) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL bp_count[%0d] got=%0d want=%0d", c, fifo_count, wr_cnt - rd_cnt);
      end
    end
    s_valid = 1'b0; fifo_rd_en = 1'b0;
    n_cmp++; if ({overflow_err, underflow_err} !== 2'b00) begin n_fail++; $display("FAIL bp_errs got=%b%b want=00", overflow_err, underflow_err); end
    $display("test_backpressure done: %0d writes, %0d reads", wr_cnt, rd_cnt);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_mid_reset();
    test_boundary();
    pulse_reset();
    test_back_to_back();
    pulse_reset();
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
